// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: key whitening, round counting, final-round flag and handshakes.
// Optional datapath watchdog enabled by defining AES_ROUND_CTRL_TIMEOUT_EN.
module aes_round_ctrl #(
  parameter int unsigned NR         = 10,
  parameter int unsigned DP_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         dp_en,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic         dp_done,
  input  logic [127:0] dp_result,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} st_e;

  localparam logic [3:0] NrVal = 4'(NR);

  st_e          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         in_round;

`ifdef AES_ROUND_CTRL_TIMEOUT_EN
  localparam int unsigned WdW = (DP_TIMEOUT < 2) ? 1 : $clog2(DP_TIMEOUT + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(DP_TIMEOUT - 1);

  logic [WdW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
`endif

  // Next-state logic; dp_done is only honoured in StWait.
  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    round_d = round_q;
`ifdef AES_ROUND_CTRL_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = 1'b0;
`endif
    unique case (st_q)
      StIdle: begin
        if (in_valid) begin
          state_d = in_block ^ rk_data;
          round_d = 4'd1;
          st_d    = StIssue;
        end
      end
      StIssue: begin
        st_d = StWait;
`ifdef AES_ROUND_CTRL_TIMEOUT_EN
        wdog_d = '0;
`endif
      end
      StWait: begin
        if (dp_done) begin
          state_d = dp_result;
          if (round_q == NrVal) begin
            st_d = StOut;
          end else begin
            round_d = round_q + 4'd1;
            st_d    = StIssue;
          end
`ifdef AES_ROUND_CTRL_TIMEOUT_EN
        end else if (wdog_q == WdLimit) begin
          // Datapath never answered: drop the block and report once.
          err_d   = 1'b1;
          state_d = '0;
          round_d = '0;
          wdog_d  = '0;
          st_d    = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      StOut: begin
        if (out_ready) begin
          round_d = '0;
          st_d    = StIdle;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= StIdle;
      state_q <= '0;
      round_q <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      round_q <= round_d;
    end
  end

`ifdef AES_ROUND_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_round = (st_q == StIssue) || (st_q == StWait);

  always_comb begin
    in_ready  = (st_q == StIdle);
    busy      = (st_q != StIdle);
    dp_en     = (st_q == StIssue);
    out_valid = (st_q == StOut);
    out_block = out_valid ? state_q : '0;
    dp_state  = in_round ? state_q : '0;
    dp_last   = in_round && (round_q == NrVal);
    rk_idx    = in_round ? round_q : 4'd0;
  end

  param_legal_a: assert property (@(posedge clk)
    (NR >= 1) && (NR <= 14) && (DP_TIMEOUT >= 1));

  out_stable_a: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(out_block));

  dp_en_pulse_a: assert property (@(posedge clk) disable iff (rst)
    dp_en |=> !dp_en);

endmodule
